// File: rtl/i2c_reg_ram_if.sv
// Bus-side signal bundle between the I2C slave byte engine (master modport)
// and the register-file RAM (slave modport).
interface i2c_reg_ram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              start;
    logic              stop;
    logic              wr_stb;
    logic [DATA_W-1:0] wr_data;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] ptr;
    logic              clear_req;
    logic              busy;
    logic              ovf;

    modport master (
        output start, stop, wr_stb, wr_data, rd_ack, clear_req,
        input  rd_data, ptr, busy, ovf
    );

    modport slave (
        input  start, stop, wr_stb, wr_data, rd_ack, clear_req,
        output rd_data, ptr, busy, ovf
    );
endinterface

// File: rtl/i2c_reg_ram.sv
// Register-file RAM shared by the I2C slave (pointer-based sequential access)
// and the LCD refresh logic (independent registered read port). A hardware
// clear sweeps FILL into every word after reset or on request.
module i2c_reg_ram #(
    parameter int                 DATA_W  = 8,
    parameter int                 ADDR_W  = 5,
    parameter int                 DEPTH   = 32,
    parameter logic [DATA_W-1:0]  FILL    = 8'hFE,
    parameter int                 WRAP_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    i2c_reg_ram_if.slave         bus,
    input  logic [ADDR_W-1:0]    lcd_radd,
    output logic [DATA_W-1:0]    lcd_dout
);
    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DATA  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state, state_n;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_n;
    logic [ADDR_W-1:0] ptr_q, ptr_n;
    logic              ovf_q, ovf_n;
    // sat_q: pointer is parked at DEPTH-1 after a non-wrapping overflow;
    // writes there are dropped until a new pointer byte is loaded.
    logic              sat_q, sat_n;

    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              do_inc;
    logic [ADDR_W-1:0] ld_val;

    assign ld_val = bus.wr_data[ADDR_W-1:0];

    // Next-state, pointer and write-port decode
    always_comb begin
        state_n   = state;
        clr_cnt_n = clr_cnt;
        ptr_n     = ptr_q;
        ovf_n     = ovf_q;
        sat_n     = sat_q;
        we        = 1'b0;
        wa        = ptr_q;
        wd        = bus.wr_data;
        do_inc    = 1'b0;

        case (state)
            ST_CLEAR: begin
                we = 1'b1;
                wa = clr_cnt;
                wd = FILL;
                if (clr_cnt == LAST) begin
                    state_n   = ST_IDLE;
                    clr_cnt_n = '0;
                end else begin
                    clr_cnt_n = clr_cnt + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (bus.start) begin
                    state_n = ST_WAIT;
                end else if (bus.clear_req) begin
                    state_n   = ST_CLEAR;
                    clr_cnt_n = '0;
                end
            end
            ST_WAIT: begin
                if (bus.start) begin
                    state_n = ST_WAIT;
                end else if (bus.stop) begin
                    state_n = ST_IDLE;
                end else if (bus.wr_stb) begin
                    state_n = ST_DATA;
                    sat_n   = 1'b0;
                    if ({1'b0, ld_val} < DEPTH_X) begin
                        ptr_n = ld_val;
                    end else begin
                        ptr_n = '0;
                        ovf_n = 1'b1;
                    end
                end else if (bus.rd_ack) begin
                    state_n = ST_DATA;
                    do_inc  = 1'b1;
                end
            end
            default: begin
                if (bus.start) begin
                    state_n = ST_WAIT;
                end else if (bus.stop) begin
                    state_n = ST_IDLE;
                end else if (bus.wr_stb) begin
                    we     = !sat_q;
                    do_inc = 1'b1;
                end else if (bus.rd_ack) begin
                    do_inc = 1'b1;
                end
            end
        endcase

        if (do_inc) begin
            if (ptr_q == LAST) begin
                if (WRAP_EN != 0) begin
                    ptr_n = '0;
                end else begin
                    ovf_n = 1'b1;
                    sat_n = 1'b1;
                end
            end else begin
                ptr_n = ptr_q + ADDR_W'(1);
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state   <= state_n;
            clr_cnt <= clr_cnt_n;
            ptr_q   <= ptr_n;
            ovf_q   <= ovf_n;
            sat_q   <= sat_n;
        end
    end

    // Single RAM write port (clear sweep or bus write)
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[wa] <= wd;
        end
    end

    // Two synchronous read ports, read-before-write
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_data <= '0;
            lcd_dout    <= '0;
        end else begin
            bus.rd_data <= mem[ptr_q];
            lcd_dout    <= mem[lcd_radd];
        end
    end

    assign bus.ptr  = ptr_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = (state == ST_CLEAR);
endmodule

// File: tb/tb_i2c_reg_ram.sv
// Directed bench for i2c_reg_ram: a wrapping DEPTH=32 instance, a saturating
// DEPTH=32 instance sharing its stimulus, and a DEPTH=20 instance driven
// separately for out-of-range pointer loads.
module tb_i2c_reg_ram;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start = 0, stop = 0, wr_stb = 0, rd_ack = 0, clear_req = 0;
    logic [7:0] wr_data = 0;
    logic [4:0] lcd_radd = 0;
    logic       en20 = 0;
    logic [7:0] lcd_a, lcd_b, lcd_c;

    int checks = 0;
    int errors = 0;

    i2c_reg_ram_if #(.DATA_W(8), .ADDR_W(5)) bus_a ();
    i2c_reg_ram_if #(.DATA_W(8), .ADDR_W(5)) bus_b ();
    i2c_reg_ram_if #(.DATA_W(8), .ADDR_W(5)) bus_c ();

    assign bus_a.start = start & ~en20;     assign bus_b.start = start & ~en20;
    assign bus_a.stop = stop & ~en20;       assign bus_b.stop = stop & ~en20;
    assign bus_a.wr_stb = wr_stb & ~en20;   assign bus_b.wr_stb = wr_stb & ~en20;
    assign bus_a.rd_ack = rd_ack & ~en20;   assign bus_b.rd_ack = rd_ack & ~en20;
    assign bus_a.clear_req = clear_req & ~en20;
    assign bus_b.clear_req = clear_req & ~en20;
    assign bus_a.wr_data = wr_data;         assign bus_b.wr_data = wr_data;
    assign bus_c.start = start & en20;
    assign bus_c.stop = stop & en20;
    assign bus_c.wr_stb = wr_stb & en20;
    assign bus_c.rd_ack = rd_ack & en20;
    assign bus_c.clear_req = clear_req & en20;
    assign bus_c.wr_data = wr_data;

    i2c_reg_ram #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .FILL(8'hFE), .WRAP_EN(1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .lcd_radd(lcd_radd), .lcd_dout(lcd_a));
    i2c_reg_ram #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .FILL(8'hFE), .WRAP_EN(0)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .lcd_radd(lcd_radd), .lcd_dout(lcd_b));
    i2c_reg_ram #(.DATA_W(8), .ADDR_W(5), .DEPTH(20), .FILL(8'hFE), .WRAP_EN(1)) dut_c (
        .clk(clk), .rst(rst), .bus(bus_c), .lcd_radd(lcd_radd), .lcd_dout(lcd_c));

    task automatic do_start();
        start = 1; @(negedge clk); start = 0;
    endtask
    task automatic do_stop();
        stop = 1; @(negedge clk); stop = 0;
    endtask
    task automatic do_wr(input logic [7:0] b);
        wr_stb = 1; wr_data = b; @(negedge clk); wr_stb = 0;
    endtask
    task automatic do_ack();
        rd_ack = 1; @(negedge clk); rd_ack = 0;
    endtask

    task automatic test_reset();
        int na, nc;
        rst = 1;
        repeat (2) @(negedge clk);
        checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b exp 1", bus_a.busy); end
        checks++; if (bus_a.ptr !== 5'd0) begin errors++; $display("FAIL rst_ptr got %0d exp 0", bus_a.ptr); end
        checks++; if (bus_a.ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", bus_a.ovf); end
        checks++; if (bus_a.rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %h exp 00", bus_a.rd_data); end
        checks++; if (lcd_a !== 8'h00) begin errors++; $display("FAIL rst_lcd_dout got %h exp 00", lcd_a); end
        rst = 0;
        na = 0; nc = 0;
        for (int i = 0; i < 100 && (bus_a.busy || bus_c.busy); i++) begin
            if (bus_a.busy) na++;
            if (bus_c.busy) nc++;
            @(negedge clk);
        end
        checks++; if (na != 32) begin errors++; $display("FAIL clear_len32 got %0d exp 32", na); end
        checks++; if (nc != 20) begin errors++; $display("FAIL clear_len20 got %0d exp 20", nc); end
        for (int i = 0; i < 32; i++) begin
            lcd_radd = 5'(i);
            @(negedge clk);
            checks++;
            if (lcd_a !== 8'hFE) begin errors++; $display("FAIL fill_sweep[%0d] got %h exp FE", i, lcd_a); end
        end
    endtask

    task automatic test_seq_write();
        do_start(); do_wr(8'h04); do_wr(8'h41); do_wr(8'h42); do_stop();
        checks++; if (bus_a.ptr !== 5'd6) begin errors++; $display("FAIL seq_ptr got %0d exp 6", bus_a.ptr); end
        lcd_radd = 5'd4; @(negedge clk);
        checks++; if (lcd_a !== 8'h41) begin errors++; $display("FAIL seq_ram4 got %h exp 41", lcd_a); end
        lcd_radd = 5'd5; @(negedge clk);
        checks++; if (lcd_a !== 8'h42) begin errors++; $display("FAIL seq_ram5 got %h exp 42", lcd_a); end
    endtask

    task automatic test_wrap();
        checks++; if (bus_b.ovf !== 1'b0) begin errors++; $display("FAIL nowrap_ovf_pre got %b exp 0", bus_b.ovf); end
        do_start(); do_wr(8'h1F); do_wr(8'hAA); do_wr(8'hBB); do_stop();
        checks++; if (bus_a.ptr !== 5'd1) begin errors++; $display("FAIL wrap_ptr got %0d exp 1", bus_a.ptr); end
        checks++; if (bus_a.ovf !== 1'b0) begin errors++; $display("FAIL wrap_ovf got %b exp 0", bus_a.ovf); end
        checks++; if (bus_b.ptr !== 5'd31) begin errors++; $display("FAIL sat_ptr got %0d exp 31", bus_b.ptr); end
        checks++; if (bus_b.ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf got %b exp 1", bus_b.ovf); end
        lcd_radd = 5'd31; @(negedge clk);
        checks++; if (lcd_a !== 8'hAA) begin errors++; $display("FAIL wrap_ram31 got %h exp AA", lcd_a); end
        checks++; if (lcd_b !== 8'hAA) begin errors++; $display("FAIL sat_ram31 got %h exp AA", lcd_b); end
        lcd_radd = 5'd0; @(negedge clk);
        checks++; if (lcd_a !== 8'hBB) begin errors++; $display("FAIL wrap_ram0 got %h exp BB", lcd_a); end
        checks++; if (lcd_b !== 8'hFE) begin errors++; $display("FAIL sat_ram0 got %h exp FE", lcd_b); end
    endtask

    task automatic test_read();
        do_start(); do_wr(8'h04); do_start();
        checks++; if (bus_a.ptr !== 5'd4) begin errors++; $display("FAIL rstart_ptr got %0d exp 4", bus_a.ptr); end
        checks++; if (bus_a.rd_data !== 8'h41) begin errors++; $display("FAIL rd_seq0 got %h exp 41", bus_a.rd_data); end
        do_ack(); @(negedge clk);
        checks++; if (bus_a.rd_data !== 8'h42) begin errors++; $display("FAIL rd_seq1 got %h exp 42", bus_a.rd_data); end
        do_ack(); @(negedge clk);
        checks++; if (bus_a.rd_data !== 8'hFE) begin errors++; $display("FAIL rd_seq2 got %h exp FE", bus_a.rd_data); end
        do_ack();
        checks++; if (bus_a.ptr !== 5'd7) begin errors++; $display("FAIL rd_ptr_end got %0d exp 7", bus_a.ptr); end
        do_stop();
    endtask

    task automatic test_ptr_range();
        en20 = 1;
        checks++; if (bus_c.ovf !== 1'b0) begin errors++; $display("FAIL d20_ovf_pre got %b exp 0", bus_c.ovf); end
        do_start(); do_wr(8'h18);
        checks++; if (bus_c.ptr !== 5'd0) begin errors++; $display("FAIL d20_ptr got %0d exp 0", bus_c.ptr); end
        checks++; if (bus_c.ovf !== 1'b1) begin errors++; $display("FAIL d20_ovf got %b exp 1", bus_c.ovf); end
        do_stop();
        en20 = 0;
        checks++; if (bus_a.ptr !== 5'd7) begin errors++; $display("FAIL d20_isolation got %0d exp 7", bus_a.ptr); end
    endtask

    task automatic test_same_cycle();
        do_start(); do_wr(8'h02);
        wr_stb = 1; wr_data = 8'h77; rd_ack = 1; lcd_radd = 5'd2;
        @(negedge clk);
        wr_stb = 0; rd_ack = 0;
        checks++; if (bus_a.ptr !== 5'd3) begin errors++; $display("FAIL same_ptr got %0d exp 3", bus_a.ptr); end
        checks++; if (lcd_a !== 8'hFE) begin errors++; $display("FAIL same_old got %h exp FE", lcd_a); end
        @(negedge clk);
        checks++; if (lcd_a !== 8'h77) begin errors++; $display("FAIL same_new got %h exp 77", lcd_a); end
        lcd_radd = 5'd3; @(negedge clk);
        checks++; if (lcd_a !== 8'hFE) begin errors++; $display("FAIL same_ram3 got %h exp FE", lcd_a); end
        do_stop();
    endtask

    task automatic test_clear();
        int n;
        clear_req = 1;
        #1;
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL clrq_early got %b exp 0", bus_a.busy); end
        @(negedge clk); clear_req = 0;
        checks++; if (bus_a.busy !== 1'b1) begin errors++; $display("FAIL clrq_busy got %b exp 1", bus_a.busy); end
        n = 0;
        for (int i = 0; i < 100 && bus_a.busy; i++) begin
            n++;
            start = (n == 3);
            wr_stb = (n == 5);
            wr_data = 8'h10;
            @(negedge clk);
        end
        start = 0; wr_stb = 0;
        checks++; if (n != 32) begin errors++; $display("FAIL clrq_len got %0d exp 32", n); end
        checks++; if (bus_a.ptr !== 5'd3) begin errors++; $display("FAIL clrq_ptr got %0d exp 3", bus_a.ptr); end
        checks++; if (bus_b.ovf !== 1'b1) begin errors++; $display("FAIL clrq_ovf got %b exp 1", bus_b.ovf); end
        do_wr(8'h10);
        checks++; if (bus_a.ptr !== 5'd3) begin errors++; $display("FAIL idle_wr_ptr got %0d exp 3", bus_a.ptr); end
        lcd_radd = 5'd4; @(negedge clk);
        checks++; if (lcd_a !== 8'hFE) begin errors++; $display("FAIL clrq_ram4 got %h exp FE", lcd_a); end
        // reset in the middle of a clear restarts the sweep
        clear_req = 1; @(negedge clk); clear_req = 0;
        repeat (10) @(negedge clk);
        rst = 1; @(negedge clk); rst = 0;
        checks++; if (bus_b.ovf !== 1'b0) begin errors++; $display("FAIL rst_mid_ovf got %b exp 0", bus_b.ovf); end
        checks++; if (bus_a.ptr !== 5'd0) begin errors++; $display("FAIL rst_mid_ptr got %0d exp 0", bus_a.ptr); end
        n = 0;
        for (int i = 0; i < 100 && bus_a.busy; i++) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != 32) begin errors++; $display("FAIL rst_mid_len got %0d exp 32", n); end
    endtask

    initial begin
        test_reset();
        test_seq_write();
        test_wrap();
        test_read();
        test_ptr_range();
        test_same_cycle();
        test_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
